// File: rtl/slave_resp_tx.sv
// slave_resp_tx
//   Slave-side response transmitter. Every beat the slave accepts
//   (data_success) is queued as {id, code, data}. One response beat per
//   queued entry is returned to the master over resp_valid/resp_ready.
//   pend_full feeds the slave's ready logic so the queue is never overrun.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   data_success one-cycle pulse per accepted beat
//   data         beat data, sampled with data_success
//   pend_full    queue holds DEPTH entries
//   resp_valid   response beat available
//   resp_ready   master accepts the response
//   resp_id      sequence id of the answered beat
//   resp_code    2'b00 OKAY, 2'b10 SLVERR (data == ERR_PATTERN)
//   resp_data    echo of the accepted data
//   overflow     sticky: a data_success pulse was dropped
//   timeout      sticky stall flag
//
// Build option
//   RESP_TIMEOUT_EN : when defined, a stall counter sets timeout after
//   TIMEOUT_CYCLES consecutive stalled cycles; otherwise timeout is 0.
module slave_resp_tx #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned ID_W           = 4,
   parameter logic [31:0] ERR_PATTERN    = 32'hDEAD_BEEF,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            data_success,
   input  logic [31:0]     data,
   output logic            pend_full,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [ID_W-1:0] resp_id,
   output logic [1:0]      resp_code,
   output logic [31:0]     resp_data,
   output logic            overflow,
   output logic            timeout
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ID_W-1:0]   id_cnt_q, id_cnt_d;
   logic              overflow_q, overflow_d;

   logic [ID_W-1:0]   mem_id   [DEPTH];
   logic [1:0]        mem_code [DEPTH];
   logic [31:0]       mem_data [DEPTH];

   logic [ID_W-1:0]   head_id_q, head_id_d;
   logic [1:0]        head_code_q, head_code_d;
   logic [31:0]       head_data_q, head_data_d;

   logic              full, pop, push_acc;
   logic [1:0]        wr_code;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign pop      = (state_q == ACTIVE) && resp_ready;
   // A push into a full queue is still taken when the head leaves this cycle.
   assign push_acc = data_success && (!full || pop);
   assign wr_code  = (data == ERR_PATTERN) ? 2'b10 : 2'b00;

   always_comb begin
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q + PTR_W'(push_acc);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      id_cnt_d   = id_cnt_q + ID_W'(push_acc);
      overflow_d = overflow_q | (data_success && full && !pop);
      case ({push_acc, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // The registered head is refreshed from the incoming beat when it becomes
   // the only entry, otherwise from storage after the old head is popped.
   always_comb begin
      head_id_d   = head_id_q;
      head_code_d = head_code_q;
      head_data_d = head_data_q;
      if (push_acc && ((count_q == '0) || (pop && count_q == CNT_W'(1)))) begin
         head_id_d   = id_cnt_q;
         head_code_d = wr_code;
         head_data_d = data;
      end else if (pop && count_q > CNT_W'(1)) begin
         head_id_d   = mem_id[rd_ptr_d];
         head_code_d = mem_code[rd_ptr_d];
         head_data_d = mem_data[rd_ptr_d];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (push_acc) state_d = ACTIVE;
         ACTIVE:  if (pop && !push_acc && count_q == CNT_W'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         id_cnt_q    <= '0;
         overflow_q  <= 1'b0;
         head_id_q   <= '0;
         head_code_q <= '0;
         head_data_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         id_cnt_q    <= id_cnt_d;
         overflow_q  <= overflow_d;
         head_id_q   <= head_id_d;
         head_code_q <= head_code_d;
         head_data_q <= head_data_d;
      end
   end

   // Storage is data only; validity is tracked by count_q and the pointers.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_id[wr_ptr_q]   <= id_cnt_q;
         mem_code[wr_ptr_q] <= wr_code;
         mem_data[wr_ptr_q] <= data;
      end
   end

   assign pend_full  = full;
   assign resp_valid = (state_q == ACTIVE);
   assign resp_id    = head_id_q;
   assign resp_code  = head_code_q;
   assign resp_data  = head_data_q;
   assign overflow   = overflow_q;

`ifdef RESP_TIMEOUT_EN
   localparam int unsigned ST_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [ST_W-1:0] stall_q, stall_d;
   logic            timeout_q, timeout_d;

   always_comb begin
      stall_d = stall_q;
      if (pop)
         stall_d = '0;
      else if (resp_valid && !resp_ready && stall_q != ST_W'(TIMEOUT_CYCLES))
         stall_d = stall_q + ST_W'(1);
      timeout_d = timeout_q | (stall_d == ST_W'(TIMEOUT_CYCLES));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         stall_q   <= stall_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_slave_resp_tx.sv
// tb_slave_resp_tx
//   Directed bench for slave_resp_tx with hand-computed expected values.
//   Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_slave_resp_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_success;
   logic [31:0] data;
   logic        pend_full;
   logic        resp_valid;
   logic        resp_ready;
   logic [3:0]  resp_id;
   logic [1:0]  resp_code;
   logic [31:0] resp_data;
   logic        overflow;
   logic        timeout;

   int n_chk  = 0;
   int n_pass = 0;

   slave_resp_tx dut (
      .clk          (clk),
      .rst          (rst),
      .data_success (data_success),
      .data         (data),
      .pend_full    (pend_full),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_id      (resp_id),
      .resp_code    (resp_code),
      .resp_data    (resp_data),
      .overflow     (overflow),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      data_success = 1'b1;
      data         = d;
      tick();
      data_success = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      data_success = 1'b0;
      data         = '0;
      resp_ready   = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check("rst_valid", 32'(resp_valid), 0);
      check("rst_full", 32'(pend_full), 0);
      check("rst_id", 32'(resp_id), 0);
      check("rst_code", 32'(resp_code), 0);
      check("rst_data", resp_data, 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_tmo", 32'(timeout), 0);

      // single beat, ready already high
      resp_ready = 1'b1;
      push(32'h0000_0011);
      check("single_valid", 32'(resp_valid), 1);
      check("single_id", 32'(resp_id), 0);
      check("single_code", 32'(resp_code), 0);
      check("single_data", resp_data, 32'h11);
      tick();
      check("single_drop", 32'(resp_valid), 0);
      tick();
      check("ready_idle", 32'(resp_valid), 0);

      // error code
      push(32'hDEAD_BEEF);
      check("err_valid", 32'(resp_valid), 1);
      check("err_id", 32'(resp_id), 1);
      check("err_code", 32'(resp_code), 2);
      check("err_data", resp_data, 32'hDEAD_BEEF);
      tick();
      check("err_drop", 32'(resp_valid), 0);

      // full with simultaneous pop: ids 2..5 queued, then push id 6 while popping id 2
      resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(32'h200 + 32'(i));
      check("fp_full", 32'(pend_full), 1);
      check("fp_head_id", 32'(resp_id), 2);
      resp_ready = 1'b1;
      push(32'h2FF);
      check("fp_ovf", 32'(overflow), 0);
      check("fp_still_full", 32'(pend_full), 1);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] exp_d;
         exp_d = (i == 3) ? 32'h2FF : 32'h201 + 32'(i);
         check("fp_drain_valid", 32'(resp_valid), 1);
         check("fp_drain_id", 32'(resp_id), 32'(3 + i));
         check("fp_drain_data", resp_data, exp_d);
         tick();
      end
      check("fp_empty", 32'(resp_valid), 0);

      // backpressure: ids 7..10 queued, fifth push dropped
      resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(32'h100 + 32'(i));
      check("bp_full", 32'(pend_full), 1);
      check("bp_ovf0", 32'(overflow), 0);
      push(32'h999);
      check("bp_ovf1", 32'(overflow), 1);
      check("bp_full2", 32'(pend_full), 1);
      for (int i = 0; i < 3; i++) begin
         check("bp_stall_valid", 32'(resp_valid), 1);
         check("bp_stall_id", 32'(resp_id), 7);
         check("bp_stall_data", resp_data, 32'h100);
         tick();
      end
`ifndef RESP_TIMEOUT_EN
      check("tmo_off", 32'(timeout), 0);
`endif
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("bp_out_id", 32'(resp_id), 32'(7 + i));
         check("bp_out_data", resp_data, 32'h100 + 32'(i));
         tick();
      end
      check("bp_empty", 32'(resp_valid), 0);
      check("bp_notfull", 32'(pend_full), 0);
      check("bp_ovf_sticky", 32'(overflow), 1);

      // reset mid-operation with 3 pending
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(32'h300 + 32'(i));
      check("mr_pending_id", 32'(resp_id), 11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_valid", 32'(resp_valid), 0);
      check("mr_full", 32'(pend_full), 0);
      check("mr_ovf", 32'(overflow), 0);
      check("mr_data", resp_data, 0);

      // id wrap: 17 back-to-back beats, ready held high
      resp_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         push(32'h400 + 32'(i));
         check("wrap_valid", 32'(resp_valid), 1);
         check("wrap_id", 32'(resp_id), 32'(i % 16));
         check("wrap_data", resp_data, 32'h400 + 32'(i));
         data_success = 1'b1;
      end
      data_success = 1'b0;
      tick();
      check("wrap_empty", 32'(resp_valid), 0);

`ifdef RESP_TIMEOUT_EN
      // stall 16 cycles with resp_valid=1
      resp_ready = 1'b0;
      push(32'h500);
      for (int i = 0; i < 15; i++) tick();
      check("tmo_15", 32'(timeout), 0);
      tick();
      check("tmo_16", 32'(timeout), 1);
      resp_ready = 1'b1;
      tick();
      check("tmo_sticky", 32'(timeout), 1);
      check("tmo_popped", 32'(resp_valid), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
